// File: rtl/boot_loader_if.sv
// Boot write port of the instruction RAM: full-word writes with a req/gnt handshake.
interface boot_loader_if #(parameter int AW = 32);
  logic          boot_req;
  logic          boot_we;
  logic [3:0]    boot_be;
  logic [AW-1:0] boot_addr;
  logic [31:0]   boot_wdata;
  logic          boot_gnt;

  modport master (output boot_req, boot_we, boot_be, boot_addr, boot_wdata, input boot_gnt);
  modport slave  (input  boot_req, boot_we, boot_be, boot_addr, boot_wdata, output boot_gnt);
endinterface

// File: rtl/boot_loader.sv
// UART byte-stream boot loader: parses A5/LEN/data/CSUM frames and writes words to instruction RAM.
// Optional macro BOOT_TIMEOUT_EN: release the CPU after TIMEOUT cycles with no sync byte.
module boot_loader #(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = AW'(32'h0000_0000),
  parameter int            MAX_WORDS = 128,
  parameter int            TIMEOUT   = 50_000_000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  boot_loader_if.master                  boot,
  output logic                           rst_boot,
  output logic                           boot_done,
  output logic                           boot_err,
  output logic [$clog2(MAX_WORDS+1)-1:0] words_loaded
);
  localparam int WLW = $clog2(MAX_WORDS+1);

  typedef enum logic [2:0] {S_SYNC, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DRAIN, S_DONE, S_ERR} state_e;

  state_e          state_q, state_d;
  logic [7:0]      len_lo_q, len_lo_d;
  logic [15:0]     len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [WLW-1:0]  widx_q, widx_d;
  logic [23:0]     asm_q, asm_d;
  logic            req_q, req_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            rst_boot_q, rst_boot_d;
  logic [WLW-1:0]  wl_q, wl_d;
  logic            ok_q, ok_d;
  logic            grant, pending, sync_hit;
  logic [15:0]     len_rx;
`ifdef BOOT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            seen_q, seen_d;
`endif

  assign grant    = req_q && boot.boot_gnt;
  assign pending  = req_q && !boot.boot_gnt;
  assign sync_hit = rx_valid && (rx_data == 8'hA5);
  assign len_rx   = {rx_data, len_lo_q};

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    sum_d      = sum_q;
    bcnt_d     = bcnt_q;
    widx_d     = widx_q;
    asm_d      = asm_q;
    req_d      = req_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    err_d      = err_q;
    rst_boot_d = rst_boot_q;
    wl_d       = wl_q;
    ok_d       = ok_q;
`ifdef BOOT_TIMEOUT_EN
    tmo_d      = tmo_q;
    seen_d     = seen_q;
`endif
    // The write handshake runs independently of the parser state.
    if (grant) begin
      req_d  = 1'b0;
      addr_d = addr_q + AW'(4);
      wl_d   = wl_q + WLW'(1);
    end
    case (state_q)
      S_SYNC, S_ERR: begin
        state_d = S_SYNC;
        if (sync_hit) begin
          state_d = S_LEN0;
          err_d   = 1'b0;
          sum_d   = '0;
          bcnt_d  = '0;
          widx_d  = '0;
          wl_d    = WLW'(grant);
`ifdef BOOT_TIMEOUT_EN
          seen_d  = 1'b1;
        end else if (!seen_q) begin
          if (tmo_q == TW'(TIMEOUT-1)) begin
            state_d    = S_DONE;
            rst_boot_d = 1'b0;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
`endif
        end
      end
      S_LEN0: if (rx_valid) begin
        len_lo_d = rx_data;
        state_d  = S_LEN1;
      end
      S_LEN1: if (rx_valid) begin
        len_d = len_rx;
        if (len_rx > 16'(MAX_WORDS)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (len_rx == 16'd0) begin
          state_d = S_CSUM;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: if (rx_valid) begin
        sum_d  = sum_q + rx_data;
        asm_d  = {rx_data, asm_q[23:8]};
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          // A word finishing while the previous one is still ungranted is dropped.
          if (pending) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            req_d   = 1'b1;
            wdata_d = {rx_data, asm_q};
            addr_d  = BASE_ADDR + (AW'(widx_q) << 2);
            widx_d  = widx_q + WLW'(1);
            if (16'(widx_q) + 16'd1 == len_q) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: if (rx_valid) begin
        ok_d    = (rx_data == sum_q);
        state_d = S_DRAIN;
      end
      S_DRAIN: if (!req_q) begin
        if (ok_q) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          rst_boot_d = 1'b0;
        end else begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_SYNC;
      len_lo_q   <= '0;
      len_q      <= '0;
      sum_q      <= '0;
      bcnt_q     <= '0;
      widx_q     <= '0;
      asm_q      <= '0;
      req_q      <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rst_boot_q <= 1'b1;
      wl_q       <= '0;
      ok_q       <= 1'b0;
`ifdef BOOT_TIMEOUT_EN
      tmo_q      <= '0;
      seen_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      bcnt_q     <= bcnt_d;
      widx_q     <= widx_d;
      asm_q      <= asm_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rst_boot_q <= rst_boot_d;
      wl_q       <= wl_d;
      ok_q       <= ok_d;
`ifdef BOOT_TIMEOUT_EN
      tmo_q      <= tmo_d;
      seen_q     <= seen_d;
`endif
    end
  end

  assign boot.boot_req   = req_q;
  assign boot.boot_we    = req_q;
  assign boot.boot_be    = {4{req_q}};
  assign boot.boot_addr  = addr_q;
  assign boot.boot_wdata = wdata_q;
  assign rst_boot        = rst_boot_q;
  assign boot_done       = done_q;
  assign boot_err        = err_q;
  assign words_loaded    = wl_q;
endmodule
